// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and delivered-instruction counter.
// Optional halt detection on CBZ XZR,#0 is compiled in with IFETCH_HALT_DETECT_EN.
module ifetch #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_F,
    input  logic         flush_D,
    input  logic         PCSrc,
    input  logic [N-1:0] PCBranch,
    output logic [5:0]   imem_addr,
    input  logic [31:0]  imem_q,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D,
    output logic [31:0]  fetch_cnt,
    output logic         halted
);

    localparam logic [31:0] HALT_WORD = 32'hB400001F;
    localparam logic [N-1:0] ALIGN_MASK = ~{{(N-2){1'b0}}, 2'b11};

    logic [N-1:0] pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [N-1:0] pcd_q, pcd_d;
    logic         valid_q, valid_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         halted_q, halted_d;
    logic         halt_hit;

    // A halt is only recognised when the word is genuinely captured into IF/ID
    // and no redirect is competing for the same edge.
`ifdef IFETCH_HALT_DETECT_EN
    assign halt_hit = (imem_q == HALT_WORD) && !flush_D && !stall_F && !PCSrc && !halted_q;
`else
    assign halt_hit = 1'b0;
`endif

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        pcd_d    = pcd_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        halted_d = halted_q | halt_hit;

        // Redirect outranks stall so a taken branch is never dropped.
        if (halted_q) begin
            pc_d = pc_q;
        end else if (PCSrc) begin
            pc_d = PCBranch & ALIGN_MASK;
        end else if (stall_F || halt_hit) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + N'(4);
        end

        if (flush_D) begin
            instr_d = 32'd0;
            pcd_d   = '0;
            valid_d = 1'b0;
        end else if (halted_q) begin
            valid_d = 1'b0;
        end else if (!stall_F) begin
            instr_d = imem_q;
            pcd_d   = pc_q;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            instr_q  <= 32'd0;
            pcd_q    <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= 32'd0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcd_q    <= pcd_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    assign imem_addr = reset ? 6'd0 : pc_q[7:2];
    assign instr_D   = instr_q;
    assign pc_D      = pcd_q;
    assign valid_D   = valid_q;
    assign fetch_cnt = cnt_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus randomized control
// against a cycle-level reference model of the fetch rules.
module tb_ifetch;

    localparam int N = 64;
    localparam logic [31:0] HALT_W = 32'hB400001F;
`ifdef IFETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         stall_F;
    logic         flush_D;
    logic         PCSrc;
    logic [N-1:0] PCBranch;
    logic [5:0]   imem_addr;
    logic [31:0]  imem_q;
    logic [31:0]  instr_D;
    logic [N-1:0] pc_D;
    logic         valid_D;
    logic [31:0]  fetch_cnt;
    logic         halted;

    logic [31:0]  rom [64];

    int total;
    int bad;

    // reference model state
    logic [63:0] m_pc, m_pcd;
    logic [31:0] m_instr, m_cnt;
    logic        m_valid, m_halt;

    ifetch #(.N(N)) dut (
        .clk(clk), .reset(reset), .stall_F(stall_F), .flush_D(flush_D),
        .PCSrc(PCSrc), .PCBranch(PCBranch), .imem_addr(imem_addr), .imem_q(imem_q),
        .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D), .fetch_cnt(fetch_cnt),
        .halted(halted)
    );

    assign imem_q = rom[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_pc = 64'd0; m_pcd = 64'd0; m_instr = 32'd0; m_cnt = 32'd0;
        m_valid = 1'b0; m_halt = 1'b0;
    endtask

    // Advance the model by one edge from the current inputs, then let the DUT take the edge.
    task automatic cycle();
        logic [63:0] npc;
        logic [31:0] w;
        logic        hit;
        w   = rom[m_pc[7:2]];
        hit = HALT_EN && !m_halt && !flush_D && !stall_F && !PCSrc && (w == HALT_W);
        if (m_halt)                npc = m_pc;
        else if (PCSrc)            npc = PCBranch & ~64'h3;
        else if (stall_F || hit)   npc = m_pc;
        else                       npc = m_pc + 64'd4;
        if (flush_D) begin
            m_instr = 32'd0; m_pcd = 64'd0; m_valid = 1'b0;
        end else if (m_halt) begin
            m_valid = 1'b0;
        end else if (!stall_F) begin
            m_instr = w; m_pcd = m_pc; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
        end
        m_halt = m_halt | hit;
        m_pc   = npc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_F = 1'b0; flush_D = 1'b0; PCSrc = 1'b0; PCBranch = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        total++;
        if ({instr_D, pc_D, valid_D, fetch_cnt, halted, imem_addr} !== '0) begin
            bad++;
            $display("FAIL reset_state: instr=%h pc_D=%h valid=%b cnt=%0d halted=%b addr=%0d, required all 0",
                     instr_D, pc_D, valid_D, fetch_cnt, halted, imem_addr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 64; k++) rom[k] = 32'(k + 1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle();
            total++;
            if (pc_D !== 64'(4 * i) || instr_D !== 32'(i + 1) || valid_D !== 1'b1) begin
                bad++;
                $display("FAIL seq_fetch[%0d]: pc_D=%h instr=%h valid=%b, required pc_D=%h instr=%h valid=1",
                         i, pc_D, instr_D, valid_D, 4 * i, i + 1);
            end
        end
        total++;
        if (fetch_cnt !== 32'd4) begin
            bad++;
            $display("FAIL seq_count: fetch_cnt=%0d, required 4", fetch_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        cycle();
        cycle();
        stall_F = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++;
            if (imem_addr !== 6'd2 || pc_D !== 64'd4 || instr_D !== 32'd2 || fetch_cnt !== 32'd2) begin
                bad++;
                $display("FAIL stall_hold[%0d]: addr=%0d pc_D=%h instr=%h cnt=%0d, required addr=2 pc_D=4 instr=2 cnt=2",
                         i, imem_addr, pc_D, instr_D, fetch_cnt);
            end
        end
        stall_F = 1'b0;
        cycle();
        cycle();
        total++;
        if (pc_D !== 64'd12 || instr_D !== 32'd4 || fetch_cnt !== 32'd4) begin
            bad++;
            $display("FAIL stall_resume: pc_D=%h instr=%h cnt=%0d, required pc_D=c instr=4 cnt=4",
                     pc_D, instr_D, fetch_cnt);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        cycle();
        stall_F = 1'b1; flush_D = 1'b1; PCSrc = 1'b1; PCBranch = 64'h2B;
        cycle();
        total++;
        if (valid_D !== 1'b0 || pc_D !== 64'd0 || instr_D !== 32'd0 || imem_addr !== 6'd10) begin
            bad++;
            $display("FAIL redirect_flush: valid=%b pc_D=%h instr=%h addr=%0d, required valid=0 pc_D=0 instr=0 addr=10",
                     valid_D, pc_D, instr_D, imem_addr);
        end
        idle_inputs();
        cycle();
        total++;
        if (pc_D !== 64'h28 || instr_D !== 32'd11 || valid_D !== 1'b1) begin
            bad++;
            $display("FAIL redirect_target: pc_D=%h instr=%h valid=%b, required pc_D=28 instr=b valid=1",
                     pc_D, instr_D, valid_D);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        PCSrc = 1'b1; PCBranch = 64'h40;
        cycle();
        idle_inputs();
        cycle();
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({instr_D, pc_D, valid_D, fetch_cnt, halted, imem_addr} !== '0) begin
            bad++;
            $display("FAIL async_reset: instr=%h pc_D=%h valid=%b cnt=%0d addr=%0d, required all 0",
                     instr_D, pc_D, valid_D, fetch_cnt, imem_addr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cycle();
        total++;
        if (pc_D !== 64'd0 || instr_D !== rom[0] || valid_D !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_fetch: pc_D=%h instr=%h valid=%b, required pc_D=0 instr=%h valid=1",
                     pc_D, instr_D, valid_D, rom[0]);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        PCSrc = 1'b1; PCBranch = {64{1'b1}};
        cycle();
        idle_inputs();
        total++;
        if (imem_addr !== 6'd63) begin
            bad++;
            $display("FAIL wrap_addr: addr=%0d, required 63", imem_addr);
        end
        cycle();
        cycle();
        total++;
        if (pc_D !== 64'd0 || instr_D !== rom[0]) begin
            bad++;
            $display("FAIL pc_wrap: pc_D=%h instr=%h, required pc_D=0 instr=%h", pc_D, instr_D, rom[0]);
        end
    endtask

    task automatic test_cnt_wrap();
        logic [63:0] fetches;
        do_reset();
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        fetches = 64'hFFFF_FFFE;
        for (int i = 0; i < 5; i++) begin
            cycle();
            fetches = fetches + 64'd1;
            if (i == 1) begin
                total++;
                if (fetch_cnt !== 32'd0) begin
                    bad++;
                    $display("FAIL cnt_wrap_zero: fetch_cnt=%h, required 0", fetch_cnt);
                end
            end
        end
        total++;
        if (fetch_cnt !== fetches[31:0] || fetch_cnt !== m_cnt) begin
            bad++;
            $display("FAIL cnt_wrap_final: fetch_cnt=%h, required %h", fetch_cnt, fetches[31:0]);
        end
    endtask

    task automatic test_halt();
        logic [31:0] saved;
        logic [31:0] cnt_at_halt;
        saved = rom[46];
        rom[46] = HALT_W;
        do_reset();
        PCSrc = 1'b1; PCBranch = 64'hB8;
        cycle();
        cycle();
        total++;
        if (halted !== 1'b0 || valid_D !== 1'b1 || instr_D !== HALT_W || pc_D !== 64'hB8) begin
            bad++;
            $display("FAIL halt_suppressed: halted=%b valid=%b instr=%h pc_D=%h, required halted=0 valid=1 instr=%h pc_D=b8",
                     halted, valid_D, instr_D, pc_D, HALT_W);
        end
        idle_inputs();
        cycle();
        total++;
        if (halted !== HALT_EN || valid_D !== 1'b1 || pc_D !== 64'hB8) begin
            bad++;
            $display("FAIL halt_capture: halted=%b valid=%b pc_D=%h, required halted=%b valid=1 pc_D=b8",
                     halted, valid_D, pc_D, HALT_EN);
        end
        cnt_at_halt = m_cnt;
`ifdef IFETCH_HALT_DETECT_EN
        for (int i = 0; i < 10; i++) begin
            cycle();
            total++;
            if (valid_D !== 1'b0 || imem_addr !== 6'd46 || fetch_cnt !== cnt_at_halt || halted !== 1'b1) begin
                bad++;
                $display("FAIL halt_frozen[%0d]: valid=%b addr=%0d cnt=%0d halted=%b, required valid=0 addr=46 cnt=%0d halted=1",
                         i, valid_D, imem_addr, fetch_cnt, halted, cnt_at_halt);
            end
        end
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_reset: halted=%b, required 0", halted);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        rom[46] = saved;
        cycle();
        total++;
        if (pc_D !== 64'd0 || valid_D !== 1'b1 || halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_restart: pc_D=%h valid=%b halted=%b, required pc_D=0 valid=1 halted=0",
                     pc_D, valid_D, halted);
        end
`else
        cycle();
        total++;
        if (pc_D !== 64'hBC || valid_D !== 1'b1 || halted !== 1'b0 || fetch_cnt !== cnt_at_halt + 32'd1) begin
            bad++;
            $display("FAIL no_halt_continue: pc_D=%h valid=%b halted=%b cnt=%0d, required pc_D=bc valid=1 halted=0 cnt=%0d",
                     pc_D, valid_D, halted, fetch_cnt, cnt_at_halt + 32'd1);
        end
        rom[46] = saved;
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 64; k++) begin
            rom[k] = $urandom;
            if (rom[k] == HALT_W) rom[k] = 32'h0;
        end
        do_reset();
        for (int i = 0; i < 400; i++) begin
            stall_F  = ($urandom_range(0, 99) < 25);
            flush_D  = ($urandom_range(0, 99) < 15);
            PCSrc    = ($urandom_range(0, 99) < 15);
            PCBranch = {$urandom, $urandom};
            cycle();
            total++;
            if (pc_D !== m_pcd || instr_D !== m_instr || valid_D !== m_valid) begin
                bad++;
                $display("FAIL rand_ifid[%0d]: pc_D=%h instr=%h valid=%b, required pc_D=%h instr=%h valid=%b",
                         i, pc_D, instr_D, valid_D, m_pcd, m_instr, m_valid);
            end
            total++;
            if (imem_addr !== m_pc[7:2] || fetch_cnt !== m_cnt || halted !== m_halt) begin
                bad++;
                $display("FAIL rand_state[%0d]: addr=%0d cnt=%0d halted=%b, required addr=%0d cnt=%0d halted=%b",
                         i, imem_addr, fetch_cnt, halted, m_pc[7:2], m_cnt, m_halt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < 64; k++) rom[k] = 32'(k + 1);
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_async_reset();
        test_pc_wrap();
        test_cnt_wrap();
        test_halt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
